// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer sitting in front of the CSR file.
//
// Takes a synchronous exception, the external interrupt or an mret at the
// commit stage. It strobes the CSR block with trap/trap_src/trap_pc, picks up
// the new fetch PC from mtvec or mepc, and issues one redirect with flush/stall.
// This block holds the only copy of mstatus.MIE and mstatus.MPIE.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   commit_valid/commit_pc     instruction at commit and its PC
//   exc_valid/exc_code         synchronous exception raised by that instruction
//   irq_pending                level-sensitive external interrupt
//   mret_valid                 commit instruction is mret
//   mstatus_we/mstatus_wdata   CSR write to mstatus (only bits 7 and 3 kept)
//   mtvec_rdata/mepc_rdata     read data from the CSR block
//   trap/trap_src/trap_pc      one-cycle trap strobe, {irq, code}, and the PC for mepc
//   mstatus_rdata              {24'b0, mpie, 3'b0, mie, 3'b0}
//   flush/stall                pipeline control
//   redirect_valid/_pc/_ready  fetch redirect handshake
module trap_ctrl #(
  parameter logic [3:0] IRQ_CODE  = 4'd11,
  parameter logic       RESET_MIE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic        irq_pending,
  input  logic        mret_valid,
  input  logic        mstatus_we,
  input  logic [31:0] mstatus_wdata,
  input  logic [31:0] mtvec_rdata,
  input  logic [31:0] mepc_rdata,
  output logic        trap,
  output logic [4:0]  trap_src,
  output logic [31:0] trap_pc,
  output logic [31:0] mstatus_rdata,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TRAP     = 2'd1;
  localparam logic [1:0] S_RET      = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  trap_src_q, trap_src_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;

  // Bits of the CSR buses that are dropped on purpose.
  logic unused_bits;
  assign unused_bits = ^{mstatus_wdata[31:8], mstatus_wdata[6:4], mstatus_wdata[2:0],
                         mtvec_rdata[1:0], mepc_rdata[1:0]};

  always_comb begin
    state_d       = state_q;
    trap_src_d    = trap_src_q;
    trap_pc_d     = trap_pc_q;
    redirect_pc_d = redirect_pc_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    case (state_q)
      S_IDLE: begin
        // The interrupt is gated by the registered MIE. An mstatus write that
        // sets MIE only takes effect for irq on the next cycle.
        if (commit_valid && exc_valid) begin
          trap_src_d = {1'b0, exc_code};
          trap_pc_d  = commit_pc;
          state_d    = S_TRAP;
        end else if (commit_valid && irq_pending && mie_q) begin
          trap_src_d = {1'b1, IRQ_CODE};
          trap_pc_d  = commit_pc;
          state_d    = S_TRAP;
        end else if (commit_valid && mret_valid) begin
          state_d = S_RET;
        end else if (mstatus_we) begin
          mie_d  = mstatus_wdata[3];
          mpie_d = mstatus_wdata[7];
        end
      end
      S_TRAP: begin
        mpie_d        = mie_q;
        mie_d         = 1'b0;
        redirect_pc_d = {mtvec_rdata[31:2], 2'b00};
        state_d       = S_REDIRECT;
      end
      S_RET: begin
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
        redirect_pc_d = {mepc_rdata[31:2], 2'b00};
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      trap_src_q    <= '0;
      trap_pc_q     <= '0;
      redirect_pc_q <= '0;
      mie_q         <= RESET_MIE;
      mpie_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      trap_src_q    <= trap_src_d;
      trap_pc_q     <= trap_pc_d;
      redirect_pc_q <= redirect_pc_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
    end
  end

  // All control outputs are decoded from registered state, so they are glitch-free.
  assign trap           = (state_q == S_TRAP);
  assign flush          = (state_q == S_TRAP) || (state_q == S_RET);
  assign stall          = (state_q != S_IDLE);
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign trap_src       = trap_src_q;
  assign trap_pc        = trap_pc_q;
  assign mstatus_rdata  = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios followed by random cycles. Every
// cycle is compared against a phase-counting reference model.
module tb_trap_ctrl;
  localparam logic [3:0] IRQ_CODE = 4'd11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, exc_valid, irq_pending, mret_valid, mstatus_we, redirect_ready;
  logic [31:0] commit_pc, mstatus_wdata, mtvec_rdata, mepc_rdata;
  logic [3:0]  exc_code;
  logic        trap, flush, stall, redirect_valid;
  logic [4:0]  trap_src;
  logic [31:0] trap_pc, mstatus_rdata, redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.IRQ_CODE(IRQ_CODE), .RESET_MIE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .irq_pending(irq_pending), .mret_valid(mret_valid),
    .mstatus_we(mstatus_we), .mstatus_wdata(mstatus_wdata),
    .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
    .trap(trap), .trap_src(trap_src), .trap_pc(trap_pc),
    .mstatus_rdata(mstatus_rdata),
    .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // Reference model. phase counts cycles since an event was accepted:
  // 0 means idle, 1 is the trap/mret cycle, and 2 or more means waiting on redirect.
  int          m_phase;
  bit          m_is_trap;
  logic [4:0]  m_src;
  logic [31:0] m_tpc, m_rpc;
  bit          m_mie, m_mpie;

  task automatic model_reset();
    m_phase = 0; m_is_trap = 0; m_src = '0; m_tpc = '0; m_rpc = '0;
    m_mie = 0; m_mpie = 0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (commit_valid && exc_valid) begin
        m_is_trap = 1; m_src = {1'b0, exc_code}; m_tpc = commit_pc; m_phase = 1;
      end else if (commit_valid && irq_pending && m_mie) begin
        m_is_trap = 1; m_src = {1'b1, IRQ_CODE}; m_tpc = commit_pc; m_phase = 1;
      end else if (commit_valid && mret_valid) begin
        m_is_trap = 0; m_phase = 1;
      end else if (mstatus_we) begin
        m_mie = mstatus_wdata[3]; m_mpie = mstatus_wdata[7];
      end
    end else if (m_phase == 1) begin
      if (m_is_trap) begin
        m_mpie = m_mie; m_mie = 0; m_rpc = mtvec_rdata & 32'hFFFF_FFFC;
      end else begin
        m_mie = m_mpie; m_mpie = 1; m_rpc = mepc_rdata & 32'hFFFF_FFFC;
      end
      m_phase = 2;
    end else begin
      m_phase = redirect_ready ? 0 : m_phase + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] ms;
    ms = 32'(m_mpie) << 7 | 32'(m_mie) << 3;
    chk("trap",           32'(trap),           32'(m_phase == 1 && m_is_trap));
    chk("flush",          32'(flush),          32'(m_phase == 1));
    chk("stall",          32'(stall),          32'(m_phase != 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_phase >= 2));
    chk("redirect_pc",    redirect_pc,         m_rpc);
    chk("trap_src",       32'(trap_src),       32'(m_src));
    chk("trap_pc",        trap_pc,             m_tpc);
    chk("mstatus_rdata",  mstatus_rdata,       ms);
  endtask

  // One clock cycle: the model sees the same inputs as the DUT edge, then compares 1ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    commit_valid = 0; exc_valid = 0; irq_pending = 0; mret_valid = 0;
    mstatus_we = 0; mstatus_wdata = 0; exc_code = 0; commit_pc = 0;
    redirect_ready = 1;
  endtask

  task automatic exc_scenario();
    quiet();
    commit_valid = 1; exc_valid = 1; exc_code = 4'd2; commit_pc = 32'h100;
    mtvec_rdata = 32'h200;
    step();
    quiet();
    chk("exc_trap",     32'(trap),     32'd1);
    chk("exc_src",      32'(trap_src), 32'h02);
    chk("exc_tpc",      trap_pc,       32'h100);
    chk("exc_flush",    32'(flush),    32'd1);
    step();
    chk("exc_rvalid",   32'(redirect_valid), 32'd1);
    chk("exc_rpc",      redirect_pc,   32'h200);
    step();
    chk("exc_idle",     32'(stall),    32'd0);
    chk("exc_mie",      32'(mstatus_rdata[3]), 32'd0);
  endtask

  initial begin
    mtvec_rdata = 0; mepc_rdata = 0;
    quiet();
    rst_n = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1;

    // Exception
    exc_scenario();

    // Interrupt. Setting MIE does not let irq through in that same cycle.
    quiet();
    mstatus_we = 1; mstatus_wdata = 32'h8; commit_valid = 1; irq_pending = 1; commit_pc = 32'h40;
    step();
    chk("irq_same_cycle_no_trap", 32'(stall), 32'd0);
    quiet();
    commit_valid = 1; irq_pending = 1; commit_pc = 32'h44; mtvec_rdata = 32'h303;
    step();
    quiet();
    chk("irq_src", 32'(trap_src), 32'h1B);
    chk("irq_tpc", trap_pc, 32'h44);
    step();
    chk("irq_mstatus", mstatus_rdata, 32'h80);
    chk("irq_rpc_aligned", redirect_pc, 32'h300);
    step();
    // With mie=0 the irq is masked.
    commit_valid = 1; irq_pending = 1; commit_pc = 32'h48;
    repeat (3) step();
    chk("irq_masked", 32'(stall), 32'd0);

    // mret after the trap
    quiet();
    commit_valid = 1; mret_valid = 1; mepc_rdata = 32'h47;
    step();
    quiet();
    chk("mret_trap", 32'(trap), 32'd0);
    chk("mret_flush", 32'(flush), 32'd1);
    step();
    chk("mret_rpc", redirect_pc, 32'h44);
    chk("mret_mstatus", mstatus_rdata, 32'h88);
    step();

    // Simultaneous events with mie=1: the exception wins.
    commit_valid = 1; exc_valid = 1; exc_code = 4'd5; irq_pending = 1; mret_valid = 1;
    commit_pc = 32'h60; mtvec_rdata = 32'h400;
    step();
    quiet();
    chk("simul_src", 32'(trap_src), 32'h05);
    redirect_ready = 0;
    step();

    // Backpressure in REDIRECT; new exceptions are dropped.
    for (int i = 0; i < 4; i++) begin
      commit_valid = i[0]; exc_valid = 1; exc_code = 4'd7; commit_pc = 32'h999;
      step();
      chk("bp_rvalid", 32'(redirect_valid), 32'd1);
      chk("bp_rpc", redirect_pc, 32'h400);
      chk("bp_no_trap", 32'(trap), 32'd0);
    end
    quiet();
    step();

    // Async reset while in REDIRECT
    commit_valid = 1; exc_valid = 1; exc_code = 4'd3; commit_pc = 32'h80; mtvec_rdata = 32'h500;
    step();
    quiet();
    redirect_ready = 0;
    step();
    step();
    chk("pre_rst_rvalid", 32'(redirect_valid), 32'd1);
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_rpc", redirect_pc, 32'h0);
    @(negedge clk);
    rst_n = 1;
    exc_scenario();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      commit_valid   = ($urandom_range(0, 3) != 0);
      exc_valid      = ($urandom_range(0, 5) == 0);
      exc_code       = 4'($urandom);
      irq_pending    = ($urandom_range(0, 3) == 0);
      mret_valid     = ($urandom_range(0, 5) == 0);
      mstatus_we     = ($urandom_range(0, 4) == 0);
      mstatus_wdata  = $urandom;
      commit_pc      = $urandom;
      mtvec_rdata    = $urandom;
      mepc_rdata     = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer directly upstream of the CSR register file.
- Arbitrates synchronous exceptions, the external interrupt and mret, and drives the CSR block's trap, trap_src and pc inputs.
- Consumes the CSR block's mtvec and mepc read data and issues a single PC redirect with flush/stall to the fetch/commit pipeline.
- Owns mstatus.MIE/MPIE.

Parameters:
IRQ_CODE, 4'd11, cause code reported for the external interrupt (machine external)
RESET_MIE, 1'b0, reset value of mstatus.MIE

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
commit_valid  in  1  instruction present at commit stage
commit_pc  in  32  PC of that instruction
exc_valid  in  1  commit instruction raised a synchronous exception
exc_code  in  4  exception cause code
irq_pending  in  1  level external interrupt request
mret_valid  in  1  commit instruction is mret
mstatus_we  in  1  CSR write to mstatus this cycle
mstatus_wdata  in  32  new mstatus value (only bits 7 and 3 kept)
mtvec_rdata  in  32  trap vector from CSR block
mepc_rdata  in  32  saved PC from CSR block
trap  out  1  one-cycle trap strobe to CSR block
trap_src  out  5  {is_interrupt, code[3:0]} to CSR block
trap_pc  out  32  PC to save into mepc
mstatus_rdata  out  32  {24'b0, mpie, 3'b0, mie, 3'b0}
flush  out  1  kill younger pipeline instructions
stall  out  1  commit stage must hold
redirect_valid  out  1  new fetch PC valid
redirect_pc  out  32  new fetch PC, word aligned
redirect_ready  in  1  fetch accepted redirect

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - trap, flush, redirect_valid all 0.
  - trap_src=0, trap_pc=0, redirect_pc=0.
  - mie=RESET_MIE, mpie=0.
- States: IDLE, TRAP, RET, REDIRECT.
- stall = (state != IDLE), registered-state decode only.
- IDLE, on each cycle with commit_valid=1, priority high to low:
  1. exc_valid: latch trap_src={0,exc_code}, trap_pc=commit_pc; go to TRAP.
  2. irq_pending && mie: latch trap_src={1,IRQ_CODE}, trap_pc=commit_pc; go to TRAP. The interrupted instruction is not committed; mepc points at it.
  3. mret_valid: go to RET.
- exc_valid, irq_pending and mret_valid are ignored when commit_valid=0 and in every non-IDLE state.
- TRAP (exactly 1 cycle):
  - trap=1 and flush=1, with trap_src and trap_pc stable.
  - Register update: mpie<=mie, mie<=0.
  - redirect_pc<={mtvec_rdata[31:2],2'b00}.
  - Next state REDIRECT.
- RET (exactly 1 cycle):
  - flush=1.
  - Register update: mie<=mpie, mpie<=1.
  - redirect_pc<={mepc_rdata[31:2],2'b00}.
  - Next state REDIRECT.
- REDIRECT:
  - redirect_valid=1; redirect_pc held stable.
  - Stay until redirect_ready=1, then IDLE.
  - redirect_ready may already be high on the first REDIRECT cycle.
- Latency: event accepted at cycle n → trap/flush at n+1 → redirect_valid from n+2. Minimum 3 cycles IDLE to IDLE.
- trap is never asserted for mret, and never for more than one cycle per event.
- mstatus writes:
  - Honoured only in IDLE, and only when no trap or mret is accepted that same cycle.
  - Effect: mie<=wdata[3], mpie<=wdata[7]. All other bits read 0.
- An irq arriving while mstatus_we sets mie is not taken until the following cycle.
- Nested events during TRAP/RET/REDIRECT are dropped. The pipeline is stalled, so upstream re-presents them.
- rst_n low in any state aborts immediately to reset values. No partial redirect survives.

Test Plan:
- Exception: IDLE, commit_valid=1, exc_valid=1, exc_code=2, commit_pc=0x100, mtvec_rdata=0x200, redirect_ready=1.
  → next cycle trap=1, trap_src=5'h02, trap_pc=0x100, flush=1.
  → following cycle redirect_valid=1, redirect_pc=0x200.
  → IDLE after 3 cycles; mie=0.
- Interrupt: write mstatus 0x8, then irq_pending=1 with commit_pc=0x44.
  → trap_src=5'h1B, trap_pc=0x44, mstatus_rdata becomes 0x80.
  → irq with mie=0 produces no trap.
- mret after trap: mepc_rdata=0x47, mpie=1.
  → trap stays 0, flush=1, redirect_pc=0x44, mie=1, mpie=1.
- Simultaneous exc_valid, irq_pending (mie=1) and mret_valid.
  → exception cause taken (trap_src[4]=0); mret ignored.
- Backpressure: redirect_ready=0 for 4 cycles in REDIRECT.
  → redirect_valid and redirect_pc held, stall=1 throughout.
  → new exc_valid pulses ignored, no second trap.
- rst_n pulsed low during REDIRECT.
  → all outputs zero asynchronously, mie=RESET_MIE; after release, first exception behaves as in the Exception scenario.
